// File: rtl/tlp_rx_tap.sv
// tlp_rx_tap
//   Passive tap on the PCIe RX AXI-Stream. Each TLP is measured at its SOP
//   beat (header + payload bytes), tagged, and either forwarded beat by beat
//   into a 64-bit RX FIFO or discarded as a whole. A one-beat hold register
//   delays every beat by one cycle so that the completion tag, which only
//   appears in beat 2, can be stamped on the SOP beat as well.
//
// Ports
//   pcie_clk, pcie_rst_n   clock, async active-low reset
//   rx_tvalid/rx_tready    observed handshake (never driven here)
//   rx_tlast/tkeep/tdata   observed beat
//   rx_tuser               core sideband, bit 14 = start of TLP
//   wr_en, din             FIFO write strobe and 115-bit word
//                          {tvalid,tlast,tkeep,tdata,tuser,tlp_len[10:0],tlp_tag[7:0]}
//   full, prog_full        FIFO status
//   tlp_count, drop_count  forwarded / dropped TLP counters (wrapping)
//   overflow               sticky, a write was attempted while full
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | between TLPs; hold may contain a tlast beat awaiting flush
// HOLD_SOP | SOP beat held, waiting for beat 2 (completion tag)
// PASS     | forwarding body beats through the hold register
// DROP     | discarding beats up to and including tlast

module tlp_rx_tap #(
  parameter logic [10:0] MAX_TLP_LEN = 11'd1024
) (
  input  logic         pcie_clk,
  input  logic         pcie_rst_n,
  input  logic         rx_tvalid,
  input  logic         rx_tready,
  input  logic         rx_tlast,
  input  logic [7:0]   rx_tkeep,
  input  logic [63:0]  rx_tdata,
  input  logic [21:0]  rx_tuser,
  output logic         wr_en,
  output logic [114:0] din,
  input  logic         full,
  input  logic         prog_full,
  output logic [31:0]  tlp_count,
  output logic [31:0]  drop_count,
  output logic         overflow
);

  localparam logic [4:0] CPL_TYPE = 5'b01010;

  typedef enum logic [1:0] {IDLE, HOLD_SOP, PASS, DROP} state_t;

  state_t       state_q, state_d;

  logic         hold_valid;
  logic         hold_last;
  logic [7:0]   hold_keep;
  logic [63:0]  hold_data;
  logic [21:0]  hold_user;

  logic [10:0]  cur_len;
  logic [7:0]   cur_tag;
  logic [7:0]   tag_d;
  logic [7:0]   wr_tag;
  logic         wr_q;
  logic         wr_d;
  logic         force_last;
  logic         hold_load;
  logic         hold_clr;
  logic         take_sop;
  logic         len_load;
  logic         drop_inc;

  logic         beat;
  logic         is_sof;
  logic [12:0]  sop_pay;
  logic [12:0]  sop_len;
  logic         sop_drop;

  assign beat   = rx_tvalid & rx_tready;
  assign is_sof = rx_tuser[14];

  // Length of the TLP whose DW0 is on the bus, in bytes.
  always_comb begin
    sop_pay = 13'd0;
    if (rx_tdata[30]) begin
      if (rx_tdata[9:0] == 10'd0) sop_pay = 13'd4096;
      else                        sop_pay = {1'b0, rx_tdata[9:0], 2'b00};
    end
    sop_len  = (rx_tdata[29] ? 13'd16 : 13'd12) + sop_pay;
    sop_drop = prog_full | (sop_len > {2'b00, MAX_TLP_LEN});
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = 1'b0;
    force_last = 1'b0;
    hold_load  = 1'b0;
    hold_clr   = 1'b0;
    take_sop   = 1'b0;
    len_load   = 1'b0;
    drop_inc   = 1'b0;
    tag_d      = cur_tag;
    wr_tag     = cur_tag;

    case (state_q)
      IDLE: begin
        // Anything held here is a tlast beat: flush it unconditionally.
        if (hold_valid) begin
          wr_d     = 1'b1;
          hold_clr = 1'b1;
        end
        if (beat) begin
          if (is_sof)          take_sop = 1'b1;
          else if (!rx_tlast)  state_d  = DROP;
        end
      end
      HOLD_SOP: begin
        if (beat) begin
          wr_d = 1'b1;
          if (is_sof) begin
            force_last = 1'b1;
            hold_clr   = 1'b1;
            take_sop   = 1'b1;
          end else begin
            if (hold_data[28:24] == CPL_TYPE) begin
              tag_d  = rx_tdata[15:8];
              wr_tag = rx_tdata[15:8];
            end
            hold_load = 1'b1;
            state_d   = rx_tlast ? IDLE : PASS;
          end
        end
      end
      PASS: begin
        if (beat) begin
          wr_d = 1'b1;
          if (is_sof) begin
            force_last = 1'b1;
            hold_clr   = 1'b1;
            take_sop   = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_d   = rx_tlast ? IDLE : PASS;
          end
        end
      end
      DROP: begin
        if (beat && rx_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // SOP decision shared by IDLE and the protocol-error path. wr_tag keeps
    // the old TLP's tag for the beat being written in the same cycle.
    if (take_sop) begin
      if (sop_drop) begin
        drop_inc = 1'b1;
        state_d  = rx_tlast ? IDLE : DROP;
      end else begin
        hold_load = 1'b1;
        len_load  = 1'b1;
        tag_d     = rx_tdata[47:40];
        state_d   = rx_tlast ? IDLE : HOLD_SOP;
      end
    end
  end

  // A full FIFO suppresses the strobe itself; the state machine never stalls.
  assign wr_en = wr_q & ~full;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      din        <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_keep  <= '0;
      hold_data  <= '0;
      hold_user  <= '0;
      cur_len    <= '0;
      cur_tag    <= '0;
      tlp_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      if (wr_d)
        din <= {1'b1, hold_last | force_last, hold_keep, hold_data, hold_user,
                cur_len, wr_tag};
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_last  <= rx_tlast;
        hold_keep  <= rx_tkeep;
        hold_data  <= rx_tdata;
        hold_user  <= rx_tuser;
      end else if (hold_clr) begin
        hold_valid <= 1'b0;
      end
      if (len_load) cur_len <= sop_len[10:0];
      cur_tag <= tag_d;
      if (drop_inc)          drop_count <= drop_count + 32'd1;
      if (wr_en && din[113]) tlp_count  <= tlp_count + 32'd1;
      if (wr_q && full)      overflow   <= 1'b1;
    end
  end

endmodule
